ttl_ls161_pseudo_counter: RTL and testbench

//  Cycle-accurate emulation of a 74LS161/74LS163 synchronous binary counter whose TTL clock
//  is a level signal (cen) sampled on the system clock; counting happens on detected cen

---
 rtl/ttl_ls161_pseudo_counter_if.sv | 27 ++
 rtl/ttl_ls161_pseudo_counter.sv | 77 +++++++
 tb/tb_ttl_ls161_pseudo_counter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ttl_ls161_pseudo_counter_if.sv
// Pin bundle for one 74LS161/163 counter stage.
//   master : drives cen/clr/load/enp/ent/din, observes q/qn/rco/edge_o
//   slave  : the counter itself
interface ttl_ls161_pseudo_counter_if #(
   parameter int unsigned W = 4
);
   logic         cen;     // TTL clock level
   logic         clr;     // clear, active high
   logic         load;    // parallel load, active high
   logic         enp;     // count enable P
   logic         ent;     // count enable T, also gates rco
   logic [W-1:0] din;     // parallel load data
   logic [W-1:0] q;       // counter value
   logic [W-1:0] qn;      // complement of q
   logic         rco;     // ripple carry out
   logic         edge_o;  // one-cycle strobe after a cen rising edge

   modport master (
      output cen, clr, load, enp, ent, din,
      input  q, qn, rco, edge_o
   );

   modport slave (
      input  cen, clr, load, enp, ent, din,
      output q, qn, rco, edge_o
   );
endinterface

// File: rtl/ttl_ls161_pseudo_counter.sv
// Cycle-accurate 74LS161/74LS163 synchronous counter for a design where the TTL clock is a
// level (cen) sampled on the system clock. A count event is a detected rising edge of cen.
// Ports:
//   clk  system clock, all state updates on posedge
//   rst  synchronous reset, active high: q=INIT, edge detector primed high, edge_o=0
//   bus  slave modport of ttl_ls161_pseudo_counter_if
//        in : cen, clr, load, enp, ent, din
//        out: q (reg), qn (reg, always ~q), rco (comb: ent & q==all ones), edge_o (reg)
// Parameters:
//   W         counter width
//   SYNC_CLR  0 = LS161 clear acts every cycle, 1 = LS163 clear only on a count event
//   INIT      value loaded into q by rst
module ttl_ls161_pseudo_counter #(
   parameter int unsigned    W        = 4,
   parameter bit             SYNC_CLR = 1'b0,
   parameter logic [W-1:0]   INIT     = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   ttl_ls161_pseudo_counter_if.slave        bus
);

   localparam logic [W-1:0] ALL_ONES = '1;

   logic [W-1:0] q_r;
   logic [W-1:0] qn_r;
   logic [W-1:0] q_nxt_c;
   logic         last_cen_r;
   logic         edge_r;
   logic         ev_c;
   logic         clr_hit_c;

   // Count event: cen high now, low on the previous sample.
   always_comb begin
      ev_c = bus.cen & ~last_cen_r;
   end

   // LS161 clear is level-sensitive on every clk; LS163 clear needs the count event.
   always_comb begin
      clr_hit_c = bus.clr & (~SYNC_CLR | ev_c);
   end

   // Next counter value, priority clear > load > count > hold.
   always_comb begin
      q_nxt_c = q_r;
      if (clr_hit_c) begin
         q_nxt_c = '0;
      end else if (ev_c && bus.load) begin
         q_nxt_c = bus.din;
      end else if (ev_c && bus.enp && bus.ent) begin
         q_nxt_c = q_r + W'(1);
      end
   end

   // State register; qn is registered from the same next value so it never diverges from ~q.
   // last_cen resets high so a cen held high across reset release is not a count event.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r        <= INIT;
         qn_r       <= ~INIT;
         last_cen_r <= 1'b1;
         edge_r     <= 1'b0;
      end else begin
         q_r        <= q_nxt_c;
         qn_r       <= ~q_nxt_c;
         last_cen_r <= bus.cen;
         edge_r     <= ev_c;
      end
   end

   assign bus.q      = q_r;
   assign bus.qn     = qn_r;
   assign bus.edge_o = edge_r;
   // Combinational so a cascaded stage sees the carry in the same cycle.
   assign bus.rco    = bus.ent & (q_r == ALL_ONES);

endmodule

// File: tb/tb_ttl_ls161_pseudo_counter.sv
// Bench for ttl_ls161_pseudo_counter: an LS161-style stage, an LS163-style stage with
// non-zero INIT on the same inputs, and an 8-bit cascade of two stages.
module tb_ttl_ls161_pseudo_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen = 1'b0;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic       enp = 1'b0;
   logic       ent = 1'b0;
   logic [3:0] din = 4'h0;
   logic       c_clr = 1'b0;
   logic       c_load = 1'b0;
   logic       c_ent = 1'b0;
   logic [7:0] c_din = 8'h00;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // Reference model state: plain integers
   int m0, m1, mc;
   bit m_last, m_edge;

   always #5 clk = ~clk;

   ttl_ls161_pseudo_counter_if #(.W(4)) if0 ();
   ttl_ls161_pseudo_counter_if #(.W(4)) if1 ();
   ttl_ls161_pseudo_counter_if #(.W(4)) if_lo ();
   ttl_ls161_pseudo_counter_if #(.W(4)) if_hi ();

   assign if0.cen = cen;   assign if1.cen = cen;
   assign if0.clr = clr;   assign if1.clr = clr;
   assign if0.load = load; assign if1.load = load;
   assign if0.enp = enp;   assign if1.enp = enp;
   assign if0.ent = ent;   assign if1.ent = ent;
   assign if0.din = din;   assign if1.din = din;

   assign if_lo.cen = cen;          assign if_hi.cen = cen;
   assign if_lo.clr = c_clr;        assign if_hi.clr = c_clr;
   assign if_lo.load = c_load;      assign if_hi.load = c_load;
   assign if_lo.enp = 1'b1;         assign if_hi.enp = 1'b1;
   assign if_lo.ent = c_ent;        assign if_hi.ent = if_lo.rco;
   assign if_lo.din = c_din[3:0];   assign if_hi.din = c_din[7:4];

   ttl_ls161_pseudo_counter #(.W(4), .SYNC_CLR(1'b0), .INIT(4'h0)) u0 (
      .clk(clk), .rst(rst), .bus(if0));
   ttl_ls161_pseudo_counter #(.W(4), .SYNC_CLR(1'b1), .INIT(4'h5)) u1 (
      .clk(clk), .rst(rst), .bus(if1));
   ttl_ls161_pseudo_counter #(.W(4), .SYNC_CLR(1'b0), .INIT(4'h0)) u_lo (
      .clk(clk), .rst(rst), .bus(if_lo));
   ttl_ls161_pseudo_counter #(.W(4), .SYNC_CLR(1'b0), .INIT(4'h0)) u_hi (
      .clk(clk), .rst(rst), .bus(if_hi));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Counter behaviour expressed as integer arithmetic on a modulus.
   function automatic int next_val(input int q, input int modulus, input bit sync_clr,
                                   input bit ev, input bit c, input bit l, input bit cnt,
                                   input int d);
      if (c && (!sync_clr || ev)) return 0;
      if (ev && l)                return d;
      if (ev && cnt)              return (q + 1) % modulus;
      return q;
   endfunction

   always @(posedge clk) begin
      bit ev;
      if (rst) begin
         m0 = 0; m1 = 5; mc = 0; m_last = 1'b1; m_edge = 1'b0;
      end else begin
         ev = cen && !m_last;
         m0 = next_val(m0, 16, 1'b0, ev, clr, load, enp && ent, int'(din));
         m1 = next_val(m1, 16, 1'b1, ev, clr, load, enp && ent, int'(din));
         // An 8-bit cascade behaves as one mod-256 counter enabled by c_ent.
         mc = next_val(mc, 256, 1'b0, ev, c_clr, c_load, c_ent, int'(c_din));
         m_last = cen;
         m_edge = ev;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("u0.q",    32'(if0.q),    32'(m0));
         check("u0.qn",   32'(if0.qn),   32'(15 - m0));
         check("u0.rco",  32'(if0.rco),  32'(ent && m0 == 15));
         check("u0.edge", 32'(if0.edge_o), 32'(m_edge));
         check("u1.q",    32'(if1.q),    32'(m1));
         check("u1.qn",   32'(if1.qn),   32'(15 - m1));
         check("u1.rco",  32'(if1.rco),  32'(ent && m1 == 15));
         check("casc.q",  32'({if_hi.q, if_lo.q}),   32'(mc));
         check("casc.qn", 32'({if_hi.qn, if_lo.qn}), 32'(255 - mc));
         check("casc.rco_lo", 32'(if_lo.rco), 32'(c_ent && (mc % 16) == 15));
         check("casc.rco_hi", 32'(if_hi.rco), 32'(c_ent && mc == 255));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic ev_step();
      cen = 1'b0; step();
      cen = 1'b1; step();
   endtask

   initial begin
      int edges;
      // Reset
      rst = 1'b1; cen = 1'b0; enp = 1'b1; ent = 1'b1; c_ent = 1'b1;
      step(); step();
      chk_en = 1'b1;
      rst = 1'b0;
      check("rst.q0",  32'(if0.q),  32'h0);
      check("rst.qn0", 32'(if0.qn), 32'hF);
      check("rst.q1",  32'(if1.q),  32'h5);
      check("rst.edge", 32'(if0.edge_o), 32'h0);

      // Free count, cen period of 4 clks
      for (int p = 0; p < 17; p++) begin
         edges = 0;
         cen = 1'b0; step(); edges += int'(if0.edge_o);
         step();             edges += int'(if0.edge_o);
         cen = 1'b1; step(); edges += int'(if0.edge_o);
         step();             edges += int'(if0.edge_o);
         check("count.q", 32'(if0.q), 32'((p + 1) % 16));
         check("count.edges", 32'(edges), 32'd1);
         if (p == 14) check("count.rco15", 32'(if0.rco), 32'h1);
      end

      // cen held high across reset release: no event until it falls and rises
      cen = 1'b1; rst = 1'b1; step(); rst = 1'b0;
      step(); step(); step();
      check("hold.q0", 32'(if0.q), 32'h0);
      check("hold.q1", 32'(if1.q), 32'h5);
      ev_step();
      check("hold.q0_after", 32'(if0.q), 32'h1);
      check("hold.q1_after", 32'(if1.q), 32'h6);

      // Clear between edges vs clear on an edge
      cen = 1'b0; step();
      load = 1'b1; din = 4'h9; cen = 1'b1; step(); load = 1'b0;
      check("ld9.q0", 32'(if0.q), 32'h9);
      clr = 1'b1; step(); clr = 1'b0;
      check("aclr.q0", 32'(if0.q), 32'h0);
      check("aclr.q1", 32'(if1.q), 32'h9);
      cen = 1'b0; step();
      cen = 1'b1; clr = 1'b1; step(); clr = 1'b0;
      check("sclr.q1", 32'(if1.q), 32'h0);

      // Load ignores enables; clear beats load
      cen = 1'b0; enp = 1'b0; step();
      cen = 1'b1; load = 1'b1; din = 4'hC; step();
      check("ldC.q0", 32'(if0.q), 32'hC);
      cen = 1'b0; step();
      cen = 1'b1; clr = 1'b1; step(); clr = 1'b0; load = 1'b0;
      check("clr_ld.q0", 32'(if0.q), 32'h0);
      check("clr_ld.q1", 32'(if1.q), 32'h0);

      // ent gates count and rco
      cen = 1'b0; step();
      cen = 1'b1; load = 1'b1; din = 4'hF; step(); load = 1'b0;
      enp = 1'b1; ent = 1'b0; #1;
      check("ent0.rco", 32'(if0.rco), 32'h0);
      ev_step();
      check("ent0.q", 32'(if0.q), 32'hF);
      ent = 1'b1; #1;
      check("ent1.rco", 32'(if0.rco), 32'h1);
      ev_step();
      check("ent1.wrap", 32'(if0.q), 32'h0);

      // Cascade wrap FF -> 00 on one event, then reset mid-count
      cen = 1'b0; step();
      cen = 1'b1; c_load = 1'b1; c_din = 8'hFE; step(); c_load = 1'b0;
      ev_step();
      check("casc.ff", 32'({if_hi.q, if_lo.q}), 32'hFF);
      check("casc.rco", 32'(if_hi.rco), 32'h1);
      ev_step();
      check("casc.wrap", 32'({if_hi.q, if_lo.q}), 32'h00);
      ev_step(); ev_step();
      cen = 1'b0; step();
      cen = 1'b1; rst = 1'b1; step(); rst = 1'b0;
      check("mid_rst.casc", 32'({if_hi.q, if_lo.q}), 32'h00);
      check("mid_rst.q1", 32'(if1.q), 32'h5);
      check("mid_rst.edge", 32'(if0.edge_o), 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst    = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 2) == 0) cen = ~cen;
         clr    = ($urandom_range(0, 11) == 0);
         load   = ($urandom_range(0, 7) == 0);
         enp    = ($urandom_range(0, 3) != 0);
         ent    = ($urandom_range(0, 3) != 0);
         din    = 4'($urandom);
         c_clr  = ($urandom_range(0, 63) == 0);
         c_load = ($urandom_range(0, 31) == 0);
         c_ent  = ($urandom_range(0, 7) != 0);
         c_din  = 8'($urandom);
         step();
      end
      rst = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
